mem_exception_commit: RTL and testbench

- MEM-stage exception commit unit; directly downstream of the EXE exception-detection logic.
- Consumes the per-instruction ExceptinPipeType vector carried into MEM, prioritises the flags to a single cause, and pulses CP0 update strobes (ExcCode, EPC, BD, BadVAddr, EXL-set/ERET).
- Issues a one-cycle pipeline flush and holds a redirect-PC handshake toward IF until it is accepted.
- Also handles Refetch (TLBR/TLBW/MTC0 EntryHi/Config) redirects and ERET returns.

---
 rtl/mem_exception_commit_pkg.sv | 49 ++++
 rtl/exc_priority_encoder.sv | 82 ++++++++
 rtl/mem_exception_commit.sv | 190 +++++++++++++++++++
 tb/tb_mem_exception_commit.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_exception_commit_pkg.sv
// Shared definitions for the MEM-stage exception commit unit.
// Contents: CP0 Cause.ExcCode constants, exception vector base/offset
// defaults, the per-instruction exception flag vector carried into MEM,
// and the commit FSM state type.
package mem_exception_commit_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_CPU  = 5'd11;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_TR   = 5'd13;

  localparam logic [31:0] EXC_BASE_BEV_DEF  = 32'hBFC0_0200;
  localparam logic [31:0] EXC_BASE_NORM_DEF = 32'h8000_0000;
  localparam logic [31:0] GEN_OFFSET_DEF    = 32'h0000_0180;
  localparam logic [31:0] REFILL_OFFSET_DEF = 32'h0000_0000;

  typedef struct packed {
    logic Interrupt;
    logic WrongAddressinIF;
    logic TLBRefillinIF;
    logic TLBInvalidinIF;
    logic ReservedInstruction;
    logic CoprocessorUnusable;
    logic Syscall;
    logic Break;
    logic Overflow;
    logic Trap;
    logic RdWrongAddressinMEM;
    logic WrWrongAddressinMEM;
    logic RdTLBRefillinMEM;
    logic RdTLBInvalidinMEM;
    logic WrTLBRefillinMEM;
    logic WrTLBInvalidinMEM;
    logic TLBModified;
    logic Eret;
    logic Refetch;
  } ExceptinPipeType;

  typedef enum logic [0:0] {IDLE, REDIRECT} exc_state_e;

endpackage

// File: rtl/exc_priority_encoder.sv
// Combinational priority encoder: reduces the MEM exception flag vector to a
// single winning cause.
// Ports:
//   except_i        exception flags of the MEM instruction
//   valid_o         any flag set (including Eret/Refetch)
//   exc_code_o      Cause.ExcCode of the winning exception
//   is_refill_o     winner is a TLB refill (selects the refill vector)
//   is_inst_addr_o  winner is an IF-side address/TLB fault (BadVAddr = PC)
//   is_data_addr_o  winner is a data-side address/TLB/Mod fault
//   is_eret_o       winner is ERET (no real exception pending)
//   is_refetch_o    winner is Refetch (no real exception pending)
module exc_priority_encoder
  import mem_exception_commit_pkg::*;
(
  input  ExceptinPipeType except_i,
  output logic            valid_o,
  output logic [4:0]      exc_code_o,
  output logic            is_refill_o,
  output logic            is_inst_addr_o,
  output logic            is_data_addr_o,
  output logic            is_eret_o,
  output logic            is_refetch_o
);

  always_comb begin
    valid_o        = |except_i;
    exc_code_o     = EXC_INT;
    is_refill_o    = 1'b0;
    is_inst_addr_o = 1'b0;
    is_data_addr_o = 1'b0;
    is_eret_o      = 1'b0;
    is_refetch_o   = 1'b0;
    if (except_i.Interrupt) begin
      exc_code_o = EXC_INT;
    end else if (except_i.WrongAddressinIF) begin
      exc_code_o     = EXC_ADEL;
      is_inst_addr_o = 1'b1;
    end else if (except_i.TLBRefillinIF) begin
      exc_code_o     = EXC_TLBL;
      is_inst_addr_o = 1'b1;
      is_refill_o    = 1'b1;
    end else if (except_i.TLBInvalidinIF) begin
      exc_code_o     = EXC_TLBL;
      is_inst_addr_o = 1'b1;
    end else if (except_i.ReservedInstruction) begin
      exc_code_o = EXC_RI;
    end else if (except_i.CoprocessorUnusable) begin
      exc_code_o = EXC_CPU;
    end else if (except_i.Syscall) begin
      exc_code_o = EXC_SYS;
    end else if (except_i.Break) begin
      exc_code_o = EXC_BP;
    end else if (except_i.Overflow) begin
      exc_code_o = EXC_OV;
    end else if (except_i.Trap) begin
      exc_code_o = EXC_TR;
    end else if (except_i.RdWrongAddressinMEM) begin
      exc_code_o     = EXC_ADEL;
      is_data_addr_o = 1'b1;
    end else if (except_i.WrWrongAddressinMEM) begin
      exc_code_o     = EXC_ADES;
      is_data_addr_o = 1'b1;
    end else if (except_i.RdTLBRefillinMEM || except_i.RdTLBInvalidinMEM) begin
      // Refill wins over invalid within the group: it picks the refill vector
      exc_code_o     = EXC_TLBL;
      is_data_addr_o = 1'b1;
      is_refill_o    = except_i.RdTLBRefillinMEM;
    end else if (except_i.WrTLBRefillinMEM || except_i.WrTLBInvalidinMEM) begin
      exc_code_o     = EXC_TLBS;
      is_data_addr_o = 1'b1;
      is_refill_o    = except_i.WrTLBRefillinMEM;
    end else if (except_i.TLBModified) begin
      exc_code_o     = EXC_MOD;
      is_data_addr_o = 1'b1;
    end else if (except_i.Eret) begin
      is_eret_o = 1'b1;
    end else if (except_i.Refetch) begin
      is_refetch_o = 1'b1;
    end
  end

endmodule

// File: rtl/mem_exception_commit.sv
// MEM-stage exception commit unit.
// Takes the prioritised MEM exception, pulses CP0 update strobes and a
// one-cycle flush, then holds a redirect request toward IF until accepted.
// Also handles ERET returns and Refetch redirects. All outputs registered.
// Ports:
//   clk, resetn (synchronous, active low)
//   MEM_* : MEM instruction valid/flags/PC/delay-slot/data address
//   CP0_* : Status.BEV, Status.EXL, current EPC
//   IF_RedirectReady : IF accepts the redirect
//   Exc_Flush, Exc_RedirectValid/PC, Exc_Busy : pipeline control
//   Exc_CP0Wr/ExcCode, Exc_EPCWr/EPC/BD, Exc_BadVAddrWr/BadVAddr, Exc_IsEret
// Optional: define EXC_PERF_COUNT_EN to add Exc_ExcCount, a saturating count
// of taken exceptions (ERET/Refetch excluded).
module mem_exception_commit
  import mem_exception_commit_pkg::*;
#(
  parameter logic [31:0] EXC_BASE_BEV  = EXC_BASE_BEV_DEF,
  parameter logic [31:0] EXC_BASE_NORM = EXC_BASE_NORM_DEF,
  parameter logic [31:0] GEN_OFFSET    = GEN_OFFSET_DEF,
  parameter logic [31:0] REFILL_OFFSET = REFILL_OFFSET_DEF
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            MEM_Valid,
  input  ExceptinPipeType MEM_ExceptType,
  input  logic [31:0]     MEM_PC,
  input  logic            MEM_IsInDelaySlot,
  input  logic [31:0]     MEM_DataAddr,
  input  logic            CP0_StatusBEV,
  input  logic            CP0_StatusEXL,
  input  logic [31:0]     CP0_EPC,
  input  logic            IF_RedirectReady,
  output logic            Exc_Flush,
  output logic            Exc_RedirectValid,
  output logic [31:0]     Exc_RedirectPC,
  output logic            Exc_CP0Wr,
  output logic [4:0]      Exc_ExcCode,
  output logic            Exc_EPCWr,
  output logic [31:0]     Exc_EPC,
  output logic            Exc_BD,
  output logic            Exc_BadVAddrWr,
  output logic [31:0]     Exc_BadVAddr,
  output logic            Exc_IsEret,
`ifdef EXC_PERF_COUNT_EN
  output logic [31:0]     Exc_ExcCount,
`endif
  output logic            Exc_Busy
);

  exc_state_e  state_q, state_d;
  logic        flush_q, flush_d, rvalid_q, rvalid_d, busy_q, busy_d;
  logic        cp0wr_q, cp0wr_d, epcwr_q, epcwr_d, bd_q, bd_d;
  logic        badwr_q, badwr_d, iseret_q, iseret_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] rpc_q, rpc_d, epc_q, epc_d, bad_q, bad_d;

  logic        enc_valid, enc_refill, enc_inst_addr, enc_data_addr, enc_eret, enc_refetch;
  logic [4:0]  enc_code;
  logic        trigger;
  logic [31:0] vec_base;

  exc_priority_encoder u_prio (
    .except_i       (MEM_ExceptType),
    .valid_o        (enc_valid),
    .exc_code_o     (enc_code),
    .is_refill_o    (enc_refill),
    .is_inst_addr_o (enc_inst_addr),
    .is_data_addr_o (enc_data_addr),
    .is_eret_o      (enc_eret),
    .is_refetch_o   (enc_refetch)
  );

  assign trigger  = MEM_Valid && (state_q == IDLE) && enc_valid;
  assign vec_base = CP0_StatusBEV ? EXC_BASE_BEV : EXC_BASE_NORM;

  always_comb begin
    state_d  = state_q;
    flush_d  = 1'b0;
    cp0wr_d  = 1'b0;
    epcwr_d  = 1'b0;
    badwr_d  = 1'b0;
    iseret_d = 1'b0;
    rvalid_d = rvalid_q;
    busy_d   = busy_q;
    rpc_d    = rpc_q;
    code_d   = code_q;
    epc_d    = epc_q;
    bd_d     = bd_q;
    bad_d    = bad_q;
    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d  = REDIRECT;
          flush_d  = 1'b1;
          rvalid_d = 1'b1;
          busy_d   = 1'b1;
          if (enc_eret) begin
            iseret_d = 1'b1;
            rpc_d    = CP0_EPC;
          end else if (enc_refetch) begin
            rpc_d = MEM_PC;
          end else begin
            cp0wr_d = 1'b1;
            code_d  = enc_code;
            // EPC/BD are frozen while already at exception level
            epcwr_d = !CP0_StatusEXL;
            epc_d   = MEM_IsInDelaySlot ? (MEM_PC - 32'd4) : MEM_PC;
            bd_d    = MEM_IsInDelaySlot;
            if (enc_inst_addr) begin
              badwr_d = 1'b1;
              bad_d   = MEM_PC;
            end else if (enc_data_addr) begin
              badwr_d = 1'b1;
              bad_d   = MEM_DataAddr;
            end
            rpc_d = vec_base + ((enc_refill && !CP0_StatusEXL) ? REFILL_OFFSET : GEN_OFFSET);
          end
        end
      end
      REDIRECT: begin
        if (IF_RedirectReady) begin
          state_d  = IDLE;
          rvalid_d = 1'b0;
          busy_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      flush_q  <= 1'b0;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      cp0wr_q  <= 1'b0;
      epcwr_q  <= 1'b0;
      badwr_q  <= 1'b0;
      iseret_q <= 1'b0;
      bd_q     <= 1'b0;
      code_q   <= 5'd0;
      rpc_q    <= 32'd0;
      epc_q    <= 32'd0;
      bad_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      flush_q  <= flush_d;
      rvalid_q <= rvalid_d;
      busy_q   <= busy_d;
      cp0wr_q  <= cp0wr_d;
      epcwr_q  <= epcwr_d;
      badwr_q  <= badwr_d;
      iseret_q <= iseret_d;
      bd_q     <= bd_d;
      code_q   <= code_d;
      rpc_q    <= rpc_d;
      epc_q    <= epc_d;
      bad_q    <= bad_d;
    end
  end

  assign Exc_Flush         = flush_q;
  assign Exc_RedirectValid = rvalid_q;
  assign Exc_RedirectPC    = rpc_q;
  assign Exc_CP0Wr         = cp0wr_q;
  assign Exc_ExcCode       = code_q;
  assign Exc_EPCWr         = epcwr_q;
  assign Exc_EPC           = epc_q;
  assign Exc_BD            = bd_q;
  assign Exc_BadVAddrWr    = badwr_q;
  assign Exc_BadVAddr      = bad_q;
  assign Exc_IsEret        = iseret_q;
  assign Exc_Busy          = busy_q;

`ifdef EXC_PERF_COUNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= 32'd0;
    end else if (cp0wr_q && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign Exc_ExcCount = cnt_q;
`endif

endmodule

// File: tb/tb_mem_exception_commit.sv
// Self-checking bench for mem_exception_commit. Expected commit results are
// queued when a trigger is driven and compared when Exc_Flush appears.
`timescale 1ns/1ps
module tb_mem_exception_commit;
  import mem_exception_commit_pkg::*;

  logic            clk = 1'b0;
  logic            resetn;
  logic            MEM_Valid;
  ExceptinPipeType MEM_ExceptType;
  logic [31:0]     MEM_PC;
  logic            MEM_IsInDelaySlot;
  logic [31:0]     MEM_DataAddr;
  logic            CP0_StatusBEV;
  logic            CP0_StatusEXL;
  logic [31:0]     CP0_EPC;
  logic            IF_RedirectReady;
  logic            Exc_Flush, Exc_RedirectValid, Exc_CP0Wr, Exc_EPCWr, Exc_BD;
  logic            Exc_BadVAddrWr, Exc_IsEret, Exc_Busy;
  logic [31:0]     Exc_RedirectPC, Exc_EPC, Exc_BadVAddr;
  logic [4:0]      Exc_ExcCode;
`ifdef EXC_PERF_COUNT_EN
  logic [31:0]     Exc_ExcCount;
`endif

  always #5 clk = ~clk;

  mem_exception_commit dut (
    .clk               (clk),
    .resetn            (resetn),
    .MEM_Valid         (MEM_Valid),
    .MEM_ExceptType    (MEM_ExceptType),
    .MEM_PC            (MEM_PC),
    .MEM_IsInDelaySlot (MEM_IsInDelaySlot),
    .MEM_DataAddr      (MEM_DataAddr),
    .CP0_StatusBEV     (CP0_StatusBEV),
    .CP0_StatusEXL     (CP0_StatusEXL),
    .CP0_EPC           (CP0_EPC),
    .IF_RedirectReady  (IF_RedirectReady),
    .Exc_Flush         (Exc_Flush),
    .Exc_RedirectValid (Exc_RedirectValid),
    .Exc_RedirectPC    (Exc_RedirectPC),
    .Exc_CP0Wr         (Exc_CP0Wr),
    .Exc_ExcCode       (Exc_ExcCode),
    .Exc_EPCWr         (Exc_EPCWr),
    .Exc_EPC           (Exc_EPC),
    .Exc_BD            (Exc_BD),
    .Exc_BadVAddrWr    (Exc_BadVAddrWr),
    .Exc_BadVAddr      (Exc_BadVAddr),
    .Exc_IsEret        (Exc_IsEret),
`ifdef EXC_PERF_COUNT_EN
    .Exc_ExcCount      (Exc_ExcCount),
`endif
    .Exc_Busy          (Exc_Busy)
  );

  logic [108:0] all_out;
  assign all_out = {Exc_Flush, Exc_RedirectValid, Exc_RedirectPC, Exc_CP0Wr, Exc_ExcCode,
                    Exc_EPCWr, Exc_EPC, Exc_BD, Exc_BadVAddrWr, Exc_BadVAddr, Exc_IsEret,
                    Exc_Busy};

  typedef struct {
    string       name;
    logic        chk_data;
    logic        cp0wr, epcwr, badwr, iseret, bd;
    logic [4:0]  code;
    logic [31:0] epc, bad, pc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  // Scoreboard: every flush pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (Exc_Flush === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_flush: got flush=1 at %0t, required no flush", $time);
      end else begin
        e = sb.pop_front();
        if ({Exc_RedirectValid, Exc_Busy} !== 2'b11) begin
          errors++;
          $display("FAIL %s valid_busy: got %b required 11", e.name,
                   {Exc_RedirectValid, Exc_Busy});
        end
        checks++;
        if (Exc_RedirectPC !== e.pc) begin
          errors++;
          $display("FAIL %s redirect_pc: got %h required %h", e.name, Exc_RedirectPC, e.pc);
        end
        checks++;
        if ({Exc_CP0Wr, Exc_EPCWr, Exc_BadVAddrWr, Exc_IsEret} !==
            {e.cp0wr, e.epcwr, e.badwr, e.iseret}) begin
          errors++;
          $display("FAIL %s strobes(cp0wr,epcwr,badwr,eret): got %b required %b", e.name,
                   {Exc_CP0Wr, Exc_EPCWr, Exc_BadVAddrWr, Exc_IsEret},
                   {e.cp0wr, e.epcwr, e.badwr, e.iseret});
        end
        if (e.chk_data) begin
          checks++;
          if (Exc_ExcCode !== e.code) begin
            errors++;
            $display("FAIL %s exc_code: got %0d required %0d", e.name, Exc_ExcCode, e.code);
          end
          checks++;
          if ({Exc_EPC, Exc_BD} !== {e.epc, e.bd}) begin
            errors++;
            $display("FAIL %s epc_bd: got %h/%b required %h/%b", e.name, Exc_EPC, Exc_BD,
                     e.epc, e.bd);
          end
        end
        if (e.badwr) begin
          checks++;
          if (Exc_BadVAddr !== e.bad) begin
            errors++;
            $display("FAIL %s badvaddr: got %h required %h", e.name, Exc_BadVAddr, e.bad);
          end
        end
      end
    end
  end

  task automatic idle_inputs();
    MEM_Valid      = 1'b0;
    MEM_ExceptType = '0;
  endtask

  // kind: 0 exception, 1 eret, 2 refetch; bad_src: 0 none, 1 PC, 2 data address
  task automatic fire(input ExceptinPipeType f, input logic [31:0] pc, input logic ds,
                      input logic [31:0] daddr, input logic exl, input logic bev,
                      input int kind, input logic [4:0] code, input int bad_src,
                      input logic refill, input string name);
    exp_t        x;
    logic [31:0] base;
    MEM_Valid         = 1'b1;
    MEM_ExceptType    = f;
    MEM_PC            = pc;
    MEM_IsInDelaySlot = ds;
    MEM_DataAddr      = daddr;
    CP0_StatusEXL     = exl;
    CP0_StatusBEV     = bev;
    base       = bev ? 32'hBFC0_0200 : 32'h8000_0000;
    x.name     = name;
    x.chk_data = (kind == 0);
    x.cp0wr    = (kind == 0);
    x.epcwr    = (kind == 0) && !exl;
    x.badwr    = (kind == 0) && (bad_src != 0);
    x.iseret   = (kind == 1);
    x.code     = code;
    x.epc      = ds ? pc - 32'd4 : pc;
    x.bd       = ds;
    x.bad      = (bad_src == 1) ? pc : daddr;
    if (kind == 1)      x.pc = CP0_EPC;
    else if (kind == 2) x.pc = pc;
    else                x.pc = (refill && !exl) ? base : base + 32'h180;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", all_out);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_syscall();
    ExceptinPipeType f;
    f = '0;
    f.Syscall = 1'b1;
    @(negedge clk);
    IF_RedirectReady = 1'b1;
    fire(f, 32'h8000_1000, 1'b0, 32'h0, 1'b0, 1'b0, 0, 5'd8, 0, 1'b0, "syscall");
    @(posedge clk);
    #1;
    idle_inputs();
    checks++;
    if (Exc_Flush !== 1'b1) begin
      errors++;
      $display("FAIL syscall_latency: got flush=%b required 1", Exc_Flush);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({Exc_Flush, Exc_CP0Wr, Exc_EPCWr, Exc_RedirectValid, Exc_Busy} !== 5'b0) begin
      errors++;
      $display("FAIL syscall_one_cycle: got %b required 00000",
               {Exc_Flush, Exc_CP0Wr, Exc_EPCWr, Exc_RedirectValid, Exc_Busy});
    end
  endtask

  task automatic test_overflow_ds();
    ExceptinPipeType f;
    f = '0;
    f.Overflow = 1'b1;
    f.RdWrongAddressinMEM = 1'b1;
    @(negedge clk);
    fire(f, 32'h8000_2004, 1'b1, 32'h1234_5671, 1'b0, 1'b0, 0, 5'd12, 0, 1'b0, "ov_ds");
    @(posedge clk);
    #1;
    idle_inputs();
    @(posedge clk);
    #1;
  endtask

  task automatic test_tlb_refill();
    ExceptinPipeType f;
    f = '0;
    f.RdTLBRefillinMEM = 1'b1;
    @(negedge clk);
    fire(f, 32'h8000_5000, 1'b0, 32'h0040_0010, 1'b0, 1'b0, 0, 5'd2, 2, 1'b1, "refill_exl0");
    @(posedge clk);
    #1;
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    fire(f, 32'h8000_5000, 1'b0, 32'h0040_0010, 1'b1, 1'b0, 0, 5'd2, 2, 1'b1, "refill_exl1");
    @(posedge clk);
    #1;
    idle_inputs();
    @(posedge clk);
    #1;
    checks++;
    if (Exc_RedirectValid !== 1'b0) begin
      errors++;
      $display("FAIL refill_return_idle: got %b required 0", Exc_RedirectValid);
    end
  endtask

  task automatic test_priority();
    ExceptinPipeType f;
    logic [4:0]  code;
    int          src;
    logic        refill, bev, ds;
    logic [31:0] pc;
    string       nm;
    for (int i = 0; i < 13; i++) begin
      f = '0;
      src = 0;
      refill = 1'b0;
      bev = 1'b0;
      ds = 1'b0;
      pc = 32'h8000_6000 + 32'(i * 16);
      case (i)
        0:  begin f.Interrupt = 1; f.Syscall = 1; f.Eret = 1; code = 5'd0; end
        1:  begin f.WrongAddressinIF = 1; f.ReservedInstruction = 1; code = 5'd4; src = 1; end
        2:  begin f.TLBRefillinIF = 1; f.Trap = 1; code = 5'd2; src = 1; refill = 1; end
        3:  begin f.TLBInvalidinIF = 1; code = 5'd2; src = 1; end
        4:  begin f.ReservedInstruction = 1; f.CoprocessorUnusable = 1; code = 5'd10; end
        5:  begin f.CoprocessorUnusable = 1; f.Break = 1; code = 5'd11; end
        6:  begin f.Break = 1; f.Overflow = 1; code = 5'd9; end
        7:  begin f.Trap = 1; f.WrWrongAddressinMEM = 1; code = 5'd13; end
        8:  begin f.WrWrongAddressinMEM = 1; f.TLBModified = 1; code = 5'd5; src = 2; end
        9:  begin f.RdTLBInvalidinMEM = 1; f.WrTLBRefillinMEM = 1; code = 5'd2; src = 2; end
        10: begin f.WrTLBRefillinMEM = 1; code = 5'd3; src = 2; refill = 1; bev = 1; end
        11: begin f.TLBModified = 1; f.Refetch = 1; code = 5'd1; src = 2; end
        default: begin f.Syscall = 1; code = 5'd8; ds = 1; pc = 32'h0; bev = 1; end
      endcase
      nm = $sformatf("prio_%0d", i);
      @(negedge clk);
      fire(f, pc, ds, 32'hC0DE_0000 + 32'(i), 1'b0, bev, 0, code, src, refill, nm);
      @(posedge clk);
      #1;
      idle_inputs();
      @(posedge clk);
      #1;
      checks++;
      if (Exc_RedirectValid !== 1'b0) begin
        errors++;
        $display("FAIL %s return_idle: got %b required 0", nm, Exc_RedirectValid);
      end
    end
  endtask

  task automatic test_refetch();
    ExceptinPipeType f, s;
    int vcnt;
    vcnt = 0;
    f = '0;
    f.Refetch = 1'b1;
    s = '0;
    s.Syscall = 1'b1;
    @(negedge clk);
    IF_RedirectReady = 1'b0;
    fire(f, 32'h8000_3000, 1'b0, 32'h0, 1'b0, 1'b0, 2, 5'd0, 0, 1'b0, "refetch");
    @(posedge clk);
    #1;
    if (Exc_RedirectValid === 1'b1) vcnt++;
    // A fresh trigger while the redirect is pending must be ignored
    MEM_Valid      = 1'b1;
    MEM_ExceptType = s;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (Exc_RedirectValid === 1'b1) vcnt++;
      checks++;
      if (Exc_RedirectPC !== 32'h8000_3000 || Exc_Busy !== 1'b1 ||
          {Exc_Flush, Exc_CP0Wr, Exc_EPCWr, Exc_BadVAddrWr, Exc_IsEret} !== 5'b0) begin
        errors++;
        $display("FAIL refetch_hold_%0d: got pc=%h busy=%b pulses=%b required %h 1 00000", i,
                 Exc_RedirectPC, Exc_Busy,
                 {Exc_Flush, Exc_CP0Wr, Exc_EPCWr, Exc_BadVAddrWr, Exc_IsEret}, 32'h8000_3000);
      end
    end
    IF_RedirectReady = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    checks++;
    if (vcnt != 5) begin
      errors++;
      $display("FAIL refetch_valid_cycles: got %0d required 5", vcnt);
    end
    checks++;
    if ({Exc_RedirectValid, Exc_Busy} !== 2'b00) begin
      errors++;
      $display("FAIL refetch_release: got %b required 00", {Exc_RedirectValid, Exc_Busy});
    end
  endtask

  task automatic test_eret();
    ExceptinPipeType f;
    f = '0;
    f.Eret = 1'b1;
    f.Refetch = 1'b1;
    @(negedge clk);
    CP0_EPC = 32'h8000_4000;
    IF_RedirectReady = 1'b1;
    fire(f, 32'h8000_8000, 1'b0, 32'h0, 1'b1, 1'b0, 1, 5'd0, 0, 1'b0, "eret");
    @(posedge clk);
    #1;
    idle_inputs();
    @(posedge clk);
    #1;
    checks++;
    if ({Exc_IsEret, Exc_RedirectValid} !== 2'b00) begin
      errors++;
      $display("FAIL eret_one_cycle: got %b required 00", {Exc_IsEret, Exc_RedirectValid});
    end
  endtask

  task automatic test_mem_valid_low();
    @(negedge clk);
    MEM_Valid = 1'b0;
    MEM_ExceptType = '0;
    MEM_ExceptType.Syscall = 1'b1;
    MEM_ExceptType.Interrupt = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      checks++;
      if ({Exc_Flush, Exc_RedirectValid, Exc_Busy} !== 3'b000) begin
        errors++;
        $display("FAIL mem_valid_low: got %b required 000",
                 {Exc_Flush, Exc_RedirectValid, Exc_Busy});
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_redirect();
    ExceptinPipeType f;
    f = '0;
    f.Break = 1'b1;
    @(negedge clk);
    IF_RedirectReady = 1'b0;
    fire(f, 32'h8000_7000, 1'b0, 32'h0, 1'b0, 1'b0, 0, 5'd9, 0, 1'b0, "pre_reset");
    @(posedge clk);
    #1;
    idle_inputs();
    @(posedge clk);
    #1;
    checks++;
    if (Exc_RedirectValid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_hold: got %b required 1", Exc_RedirectValid);
    end
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_mid_redirect: got %h required 0", all_out);
    end
    @(negedge clk);
    resetn = 1'b1;
    IF_RedirectReady = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (Exc_RedirectValid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got %b required 0", Exc_RedirectValid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    resetn            = 1'b0;
    MEM_Valid         = 1'b0;
    MEM_ExceptType    = '0;
    MEM_PC            = 32'h0;
    MEM_IsInDelaySlot = 1'b0;
    MEM_DataAddr      = 32'h0;
    CP0_StatusBEV     = 1'b0;
    CP0_StatusEXL     = 1'b0;
    CP0_EPC           = 32'h0;
    IF_RedirectReady  = 1'b1;
    test_reset();
    test_syscall();
    test_overflow_ds();
    test_tlb_refill();
    test_priority();
    test_refetch();
    test_eret();
    test_mem_valid_low();
    test_reset_mid_redirect();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
